// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue bus between the decode stage (master) and the hazard scoreboard (slave).
// Carries the candidate instruction, the stall/enable controls and the stall statistics.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   IssueValid;
    logic                   FlushID;
    logic [1:0]             IssueClass;
    logic                   IssueWrites;
    logic [REG_ADDR_W-1:0]  IssueDest;
    logic [REG_ADDR_W-1:0]  SrcA;
    logic [REG_ADDR_W-1:0]  SrcB;
    logic                   SrcAUsed;
    logic                   SrcBUsed;
    logic                   IsBranch;
    logic                   ClearStats;
    logic                   Stall;
    logic                   PCWriteEnable;
    logic                   IFIDWriteEnable;
    logic                   IDEXFlush;
    logic                   MulDivBusy;
    logic [STALL_CNT_W-1:0] StallCount;

    modport master (
        output IssueValid, FlushID, IssueClass, IssueWrites, IssueDest,
               SrcA, SrcB, SrcAUsed, SrcBUsed, IsBranch, ClearStats,
        input  Stall, PCWriteEnable, IFIDWriteEnable, IDEXFlush, MulDivBusy, StallCount
    );

    modport slave (
        input  IssueValid, FlushID, IssueClass, IssueWrites, IssueDest,
               SrcA, SrcB, SrcAUsed, SrcBUsed, IsBranch, ClearStats,
        output Stall, PCWriteEnable, IFIDWriteEnable, IDEXFlush, MulDivBusy, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Per-register countdown scoreboard detecting RAW, WAW and mul/div structural hazards in ID,
// producing a zero-latency stall plus a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned LOAD_LATENCY   = 1,
    parameter int unsigned MULDIV_LATENCY = 4,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input logic                 Clk,
    input logic                 Reset,
    hazard_scoreboard_if.slave  bus
);
    localparam int unsigned MaxLat = (MULDIV_LATENCY > LOAD_LATENCY) ?
                                     MULDIV_LATENCY + 1 : LOAD_LATENCY + 1;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    logic [CntW-1:0]        cnt_q [NUM_REGS];
    logic [CntW-1:0]        cnt_d [NUM_REGS];
    logic [3:0]             md_cnt_q, md_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [CntW-1:0] lat, cnt_a, cnt_b, cnt_dst;
    logic            raw_a, raw_b, waw, structural, hazard, stall, issue, dest_load, md_busy;

    always_comb begin
        unique case (bus.IssueClass)
            2'd0:    lat = CntW'(1);
            2'd1:    lat = CntW'(LOAD_LATENCY + 1);
            2'd2:    lat = CntW'(MULDIV_LATENCY + 1);
            default: lat = '0;
        endcase
    end

    // Register 0 is never tracked, so its lookups always yield zero.
    always_comb begin
        cnt_a   = '0;
        cnt_b   = '0;
        cnt_dst = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (bus.SrcA == REG_ADDR_W'(i))      cnt_a   = cnt_q[i];
            if (bus.SrcB == REG_ADDR_W'(i))      cnt_b   = cnt_q[i];
            if (bus.IssueDest == REG_ADDR_W'(i)) cnt_dst = cnt_q[i];
        end
    end

    assign md_busy = (md_cnt_q != 4'd0);

    // Non-branch consumers forward from EX/MEM, so a count of 1 is harmless for them.
    assign raw_a = bus.SrcAUsed && (bus.IsBranch ? (cnt_a != '0) : (cnt_a > CntW'(1)));
    assign raw_b = bus.SrcBUsed && (bus.IsBranch ? (cnt_b != '0) : (cnt_b > CntW'(1)));
    assign waw        = bus.IssueWrites && (bus.IssueDest != '0) && (cnt_dst > lat);
    assign structural = (bus.IssueClass == 2'd2) && md_busy;
    assign hazard     = raw_a || raw_b || waw || structural;

    assign stall     = Reset && bus.IssueValid && !bus.FlushID && hazard;
    assign issue     = Reset && bus.IssueValid && !bus.FlushID && !stall;
    assign dest_load = issue && bus.IssueWrites && (bus.IssueDest != '0) &&
                       (bus.IssueClass != 2'd3);

    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CntW'(1) : '0;
            if (dest_load && (bus.IssueDest == REG_ADDR_W'(i))) begin
                cnt_d[i] = lat;
            end
        end
    end

    // The issue cycle itself is the first occupied cycle, so only the remainder is counted.
    always_comb begin
        md_cnt_d = md_busy ? md_cnt_q - 4'd1 : 4'd0;
        if (issue && (bus.IssueClass == 2'd2)) begin
            md_cnt_d = 4'(MULDIV_LATENCY - 1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.ClearStats) begin
            stall_cnt_d = '0;
        end else if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Stall           = stall;
    assign bus.IDEXFlush       = stall;
    assign bus.PCWriteEnable   = !stall;
    assign bus.IFIDWriteEnable = !stall;
    assign bus.MulDivBusy      = md_busy;
    assign bus.StallCount      = stall_cnt_q;
endmodule
